pb_debounce_array: RTL and testbench

Multi-channel, parametrised push-button debouncer for SpartanMC peripherals such as contrast_box. It takes CHANNELS asynchronous, glitchy button inputs and synchronises each one. A shared prescaler time-bases per-channel stability counters, so long debounce windows need only narrow counters. Each channel produces a clean level, one-cycle press and release strobes, and optionally auto-repeat strobes for the peripheral register logic.

---
 rtl/debounce_pkg.sv | 25 ++
 rtl/debounce_channel.sv | 123 ++++++++++++
 rtl/pb_debounce_array.sv | 59 +++++
 tb/tb_pb_debounce_array.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared constants and helpers for pb_debounce_array
// Default parameter values, synchroniser depth and width helpers.
package debounce_pkg;

  localparam int SYNC_STAGES = 2;

  localparam int DEF_CHANNELS     = 4;
  localparam int DEF_PRESCALE     = 1000;
  localparam int DEF_STABLE_TICKS = 16;
  localparam int DEF_ACTIVE_LOW   = 1;
  localparam int DEF_REPEAT_DELAY = 500;
  localparam int DEF_REPEAT_RATE  = 100;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one debounced button: synchroniser, stability window, strobes
// Auto-repeat logic is built only when PB_DEBOUNCE_REPEAT_EN is defined.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int PRESCALE_UNUSED = 0,
  parameter int STABLE_TICKS    = DEF_STABLE_TICKS,
  parameter int ACTIVE_LOW      = DEF_ACTIVE_LOW,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick_i,
  input  logic pb_raw_i,
  output logic state_o,
  output logic down_o,
  output logic up_o,
  output logic repeat_o
);

  localparam int   CW   = max2(1, clog2(STABLE_TICKS));
  localparam logic IDLE = (ACTIVE_LOW != 0);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   state_q, state_d;
  logic                   down_q, down_d;
  logic                   up_q, up_d;
  logic                   act;
  logic                   accept;

  // Synchroniser resets to the released level so a held button needs a full window.
  assign act    = sync_q[SYNC_STAGES-1] ^ IDLE;
  assign accept = tick_i && (act != state_q) && (cnt_q == CW'(STABLE_TICKS - 1));

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pb_raw_i};
    state_d = state_q;
    cnt_d   = cnt_q;
    down_d  = 1'b0;
    up_d    = 1'b0;
    if (act == state_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (accept) begin
        state_d = ~state_q;
        cnt_d   = '0;
        down_d  = ~state_q;
        up_d    = state_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q  <= {SYNC_STAGES{IDLE}};
      cnt_q   <= '0;
      state_q <= 1'b0;
      down_q  <= 1'b0;
      up_q    <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      down_q  <= down_d;
      up_q    <= up_d;
    end
  end

  assign state_o = state_q;
  assign down_o  = down_q;
  assign up_o    = up_q;

`ifdef PB_DEBOUNCE_REPEAT_EN
  localparam int HW = max2(1, clog2(max2(REPEAT_DELAY, REPEAT_RATE) + 1));

  logic [HW-1:0] hold_q, hold_d;
  logic [HW-1:0] thr_m1;
  logic          rate_q, rate_d;
  logic          rep_q, rep_d;

  // First strobe waits REPEAT_DELAY ticks, later ones REPEAT_RATE; a releasing tick wins.
  assign thr_m1 = rate_q ? HW'(REPEAT_RATE - 1) : HW'(REPEAT_DELAY - 1);

  always_comb begin
    hold_d = hold_q;
    rate_d = rate_q;
    rep_d  = 1'b0;
    if (!state_q) begin
      hold_d = '0;
      rate_d = 1'b0;
    end else if (tick_i && !accept) begin
      if (hold_q == thr_m1) begin
        hold_d = '0;
        rate_d = 1'b1;
        rep_d  = 1'b1;
      end else begin
        hold_d = hold_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_q <= '0;
      rate_q <= 1'b0;
      rep_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rate_q <= rate_d;
      rep_q  <= rep_d;
    end
  end

  assign repeat_o = rep_q;
`else
  assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/pb_debounce_array.sv
// rtl/pb_debounce_array.sv - multi-channel push-button debouncer with shared prescaler
// Define PB_DEBOUNCE_REPEAT_EN to build per-channel auto-repeat strobes.
module pb_debounce_array
  import debounce_pkg::*;
#(
  parameter int CHANNELS     = DEF_CHANNELS,
  parameter int PRESCALE     = DEF_PRESCALE,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int ACTIVE_LOW   = DEF_ACTIVE_LOW,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] pb_in,
  output logic [CHANNELS-1:0] pb_state,
  output logic [CHANNELS-1:0] pb_down,
  output logic [CHANNELS-1:0] pb_up,
  output logic [CHANNELS-1:0] pb_repeat
);

  localparam int PW = max2(1, clog2(PRESCALE));

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;

  assign tick = (pre_q == PW'(PRESCALE - 1));

  always_comb begin
    pre_d = tick ? '0 : pre_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS (STABLE_TICKS),
      .ACTIVE_LOW   (ACTIVE_LOW),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .tick_i   (tick),
      .pb_raw_i (pb_in[g]),
      .state_o  (pb_state[g]),
      .down_o   (pb_down[g]),
      .up_o     (pb_up[g]),
      .repeat_o (pb_repeat[g])
    );
  end

endmodule

// File: tb/tb_pb_debounce_array.sv
// tb/tb_pb_debounce_array.sv - directed self-checking bench for pb_debounce_array
// Repeat checks follow PB_DEBOUNCE_REPEAT_EN.
module tb_pb_debounce_array;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] pb_in;
  logic [1:0] pb_state, pb_down, pb_up, pb_repeat;

  int errors = 0;
  int checks = 0;
  int down_cnt [2];
  int up_cnt   [2];
  int rep_cnt  [2];
  int lat;

  always #5 clk = ~clk;

  pb_debounce_array #(
    .CHANNELS     (2),
    .PRESCALE     (4),
    .STABLE_TICKS (3),
    .ACTIVE_LOW   (1),
    .REPEAT_DELAY (5),
    .REPEAT_RATE  (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pb_in     (pb_in),
    .pb_state  (pb_state),
    .pb_down   (pb_down),
    .pb_up     (pb_up),
    .pb_repeat (pb_repeat)
  );

  // Strobe counters update just after each falling edge.
  always begin
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (pb_down[i] === 1'b1)   down_cnt[i]++;
      if (pb_up[i] === 1'b1)     up_cnt[i]++;
      if (pb_repeat[i] === 1'b1) rep_cnt[i]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      down_cnt[i] = 0;
      up_cnt[i]   = 0;
      rep_cnt[i]  = 0;
    end
  endtask

  task automatic wait_state(input int ch, input logic val, input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pb_state[ch] !== val && n < bound);
  endtask

  task automatic wait_repeat(input int ch, input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pb_repeat[ch] !== 1'b1 && n < bound);
  endtask

  initial begin
    reset_n = 1'b0;
    pb_in   = 2'b11;
    clear_counts();
    cycles(3);
    check("reset_state",  pb_state,  0);
    check("reset_down",   pb_down,   0);
    check("reset_up",     pb_up,     0);
    check("reset_repeat", pb_repeat, 0);
    reset_n = 1'b1;
    cycles(5);
    check("idle_state", pb_state, 0);

    // Clean press on channel 0
    clear_counts();
    pb_in[0] = 1'b0;
    wait_state(0, 1'b1, 30, lat);
    check("press_latency_in_11_14", (lat >= 11 && lat <= 14), 1);
    check("press_down_coincident", pb_down[0], 1);
    cycles(1);
    check("press_down_one_cycle", pb_down[0], 0);
    cycles(2);
    check("press_down_count", down_cnt[0], 1);
    check("press_ch1_state", pb_state[1], 0);
    check("press_ch1_down", down_cnt[1], 0);

    // Release channel 0
    clear_counts();
    pb_in[0] = 1'b1;
    wait_state(0, 1'b0, 30, lat);
    check("release_latency_in_11_14", (lat >= 11 && lat <= 14), 1);
    check("release_up_coincident", pb_up[0], 1);
    cycles(3);
    check("release_up_count", up_cnt[0], 1);
    check("release_no_down", down_cnt[0], 0);

    // Bounce: 8 low, 1 high, five times
    clear_counts();
    for (int k = 0; k < 5; k++) begin
      pb_in[0] = 1'b0;
      cycles(8);
      pb_in[0] = 1'b1;
      cycles(1);
    end
    cycles(3);
    check("bounce_state", pb_state[0], 0);
    check("bounce_no_down", down_cnt[0], 0);
    check("bounce_no_up", up_cnt[0], 0);
    pb_in[0] = 1'b0;
    wait_state(0, 1'b1, 30, lat);
    check("bounce_hold_latency_in_11_14", (lat >= 11 && lat <= 14), 1);
    cycles(3);
    check("bounce_hold_down_count", down_cnt[0], 1);
    pb_in[0] = 1'b1;
    wait_state(0, 1'b0, 30, lat);
    cycles(2);

    // Auto-repeat on channel 1
    clear_counts();
    pb_in[1] = 1'b0;
    wait_state(1, 1'b1, 30, lat);
    check("rep_press_down", pb_down[1], 1);
`ifdef PB_DEBOUNCE_REPEAT_EN
    wait_repeat(1, 40, lat);
    check("rep_first_delay", lat, 20);
    wait_repeat(1, 40, lat);
    check("rep_second_gap", lat, 8);
    wait_repeat(1, 40, lat);
    check("rep_third_gap", lat, 8);
`else
    cycles(40);
    check("rep_disabled", rep_cnt[1], 0);
`endif
    pb_in[1] = 1'b1;
    wait_state(1, 1'b0, 30, lat);
    clear_counts();
    check("rep_release_up", pb_up[1], 1);
    check("rep_none_at_up", pb_repeat[1], 0);
    cycles(40);
    check("rep_none_after_up", rep_cnt[1], 0);
    check("rep_release_up_count", up_cnt[1], 1);

    // Reset six cycles into a press window
    clear_counts();
    pb_in[0] = 1'b0;
    cycles(6);
    check("rst_mid_before", pb_state[0], 0);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", {pb_state, pb_down, pb_up, pb_repeat}, 0);
    reset_n = 1'b1;
    lat = 1;
    do begin
      @(negedge clk);
      lat++;
    end while (pb_state[0] !== 1'b1 && lat < 40);
    check("rst_mid_latency_in_13_16", (lat >= 13 && lat <= 16), 1);
    check("rst_mid_down", pb_down[0], 1);
    cycles(3);
    check("rst_mid_down_count", down_cnt[0], 1);
    pb_in[0] = 1'b1;
    wait_state(0, 1'b0, 30, lat);
    cycles(2);

    // Simultaneous press on both channels
    clear_counts();
    pb_in = 2'b00;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (pb_state === 2'b00 && lat < 30);
    check("sim_down_both", pb_down, 2'b11);
    check("sim_state_both", pb_state, 2'b11);
    cycles(6);
    check("sim_state_held", pb_state, 2'b11);
    check("sim_down_count0", down_cnt[0], 1);
    check("sim_down_count1", down_cnt[1], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
